// File: rtl/shift_add_mult.sv
// Iterative unsigned shift-and-add multiplier: one multiplier bit per clock,
// with a ripple-carry adder built from half/full-adder cells.

module shift_add_mult_half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module shift_add_mult_full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;
    assign p  = x ^ y;
    assign s  = p ^ ci;
    assign co = (x & y) | (ci & p);
endmodule

// WIDTH-bit ripple adder; the result keeps the carry out as its top bit.
module shift_add_mult_ripple_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH:0]   sum
);
    logic [WIDTH-1:0] carry;

    shift_add_mult_half_adder u_ha0 (
        .x (x[0]),
        .y (y[0]),
        .s (sum[0]),
        .c (carry[0])
    );

    for (genvar i = 1; i < WIDTH; i++) begin : g_fa
        shift_add_mult_full_adder u_fa (
            .x  (x[i]),
            .y  (y[i]),
            .ci (carry[i-1]),
            .s  (sum[i]),
            .co (carry[i])
        );
    end

    assign sum[WIDTH] = carry[WIDTH-1];
endmodule

// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; ready and valid are decoded from the state register only, so
// neither depends combinationally on the other side's signal.
module shift_add_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic [1:0]         state
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      count_q;
    logic [2*WIDTH-1:0] product_q;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_shift;
    logic               last_step;
    logic               accept;
    logic               release_out;

    assign addend    = acc_q[0] ? mcand_q : '0;
    assign acc_shift = {sum, acc_q[WIDTH-1:1]};
    assign last_step = (count_q == CW'(WIDTH - 1));

    shift_add_mult_ripple_adder #(.WIDTH(WIDTH)) u_adder (
        .x   (acc_q[2*WIDTH-1:WIDTH]),
        .y   (addend),
        .sum (sum)
    );

    assign accept      = (state_q == IDLE) && in_valid;
    assign release_out = (state_q == DONE) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    if (release_out) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The product register is loaded once with the final shifted word and is
    // left alone afterwards, so it stays valid through any output stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q   <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        mcand_q <= a;
                        acc_q   <= {{WIDTH{1'b0}}, b};
                        count_q <= '0;
                    end
                end
                RUN: begin
                    acc_q   <= acc_shift;
                    count_q <= count_q + CW'(1);
                    if (last_step) begin
                        product_q <= acc_shift;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = product_q;
    assign state     = state_q;
endmodule

// File: tb/tb_shift_add_mult.sv
// Directed and table-driven bench for shift_add_mult (WIDTH=8), with a
// queue-based scoreboard for the randomized handshake run.

module tb_shift_add_mult;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;
    logic [1:0]     state;

    int checks   = 0;
    int failures = 0;

    logic [2*W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0]   va;
        logic [W-1:0]   vb;
        logic [2*W-1:0] vexp;
    } vec_t;

    vec_t vecs[10];

    shift_add_mult #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy),
        .state     (state)
    );

    // Clock and reset-free idle defaults
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Waits (bounded) for out_valid, returning cycles since the accept edge.
    task automatic wait_out_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Runs one full operation from IDLE; called on a falling edge.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic [2*W-1:0] exp, input string name);
        int lat;
        a = oa;
        b = ob;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check({name, "_busy"}, 32'(busy), 32'd1);
        wait_out_valid(lat);
        check({name, "_latency"}, 32'(lat), 32'd8);
        check({name, "_product"}, 32'(product), 32'(exp));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({name, "_ready_rise"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int seen;
        int received;

        vecs[0] = '{8'd13,  8'd11,  16'd143};
        vecs[1] = '{8'd0,   8'd200, 16'd0};
        vecs[2] = '{8'd255, 8'd1,   16'd255};
        vecs[3] = '{8'd1,   8'd255, 16'd255};
        vecs[4] = '{8'd255, 8'd255, 16'd65025};
        vecs[5] = '{8'd6,   8'd7,   16'd42};
        vecs[6] = '{8'd128, 8'd2,   16'd256};
        vecs[7] = '{8'd170, 8'd85,  16'd14450};
        vecs[8] = '{8'd254, 8'd3,   16'd762};
        vecs[9] = '{8'd2,   8'd3,   16'd6};

        // Reset with in_valid and out_ready active: reset must win.
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        a = 8'd5;
        b = 8'd5;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("rst_no_accept", 32'(busy), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vexp, $sformatf("vec%0d", i));
        end

        // Back-pressure: hold 42 while new operands wait.
        a = 8'd6;
        b = 8'd7;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out_valid(lat);
        check("bp_latency", 32'(lat), 32'd8);
        a = 8'd3;
        b = 8'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_product", 32'(product), 32'd42);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_product_held", 32'(product), 32'd42);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_next_accept", 32'(busy), 32'd1);
        wait_out_valid(lat);
        check("bp_next_latency", 32'(lat), 32'd8);
        check("bp_next_product", 32'(product), 32'd9);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset sampled at E4 of a running 100*100.
        a = 8'd100;
        b = 8'd100;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_product", 32'(product), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen = 1;
            @(negedge clk);
        end
        check("midrst_no_valid", 32'(seen), 32'd0);
        run_op(8'd2, 8'd3, 16'd6, "midrst_follow");

        // Randomized run: driver and monitor with a scoreboard queue.
        received = 0;
        fork
            begin : driver
                logic [W-1:0] ra;
                logic [W-1:0] rb;
                int wait_cnt;
                for (int i = 0; i < 1000; i++) begin
                    in_valid = 1'b0;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    ra = W'($urandom_range(0, 255));
                    rb = W'($urandom_range(0, 255));
                    a = ra;
                    b = rb;
                    in_valid = 1'b1;
                    wait_cnt = 0;
                    while (!in_ready && wait_cnt < 200) begin
                        @(negedge clk);
                        wait_cnt++;
                    end
                    if (wait_cnt >= 200) begin
                        check("rand_accept_timeout", 32'(wait_cnt), 32'd0);
                    end else begin
                        exp_q.push_back(16'(ra) * 16'(rb));
                    end
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            begin : monitor
                int cyc;
                logic [2*W-1:0] exp_p;
                cyc = 0;
                while (received < 1000 && cyc < 40000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("rand_unexpected_result", 32'(product), 32'hffff_ffff);
                        end else begin
                            exp_p = exp_q.pop_front();
                            check("rand_product", 32'(product), 32'(exp_p));
                        end
                        received++;
                    end
                end
                out_ready = 1'b0;
            end
        join
        check("rand_received", 32'(received), 32'd1000);
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Iterative unsigned shift-and-add multiplier: one multiplier bit retired per clock, using an adder datapath built from the team's half/full-adder cells. Sits directly upstream of result consumers and downstream of operand sources. Single-entry: one operation in flight, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 8, operand width in bits (≥2); product is 2*WIDTH bits
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  multiplicand, unsigned
- b  input  WIDTH  multiplier, unsigned
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  2*WIDTH  a*b, unsigned, exact
- busy  output  1  high in RUN or DONE

## Operation
- Reset: one clock, synchronous, active-high. All outputs are forced regardless of other inputs while rst is sampled high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, internal count=0.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready at an edge: latch mcand=a and acc={WIDTH'b0, b}, set count=0, go to RUN.
  - RUN: each edge computes sum = acc[2W-1:W] + (acc[0] ? mcand : 0) as a WIDTH+1-bit value, including carry. It then sets acc = {sum, acc[W-1:1]}, a right shift of the full {carry, hi, lo} word, and count++. After the edge where count reaches WIDTH-1, go to DONE.
  - DONE: out_valid=1, product=acc. On out_valid&&out_ready at an edge: go to IDLE, out_valid=0.
- product is registered and holds its value from entry into DONE until the next acceptance. It is not cleared on leaving DONE.
- Width rule: the intermediate sum is WIDTH+1 bits. The carry must never be dropped, so (2^W-1)^2 must be exact.
- in_valid in RUN or DONE is ignored. in_ready is low there, and a/b are not sampled.
- out_ready outside DONE is ignored.
- There is no combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Timing
- The accept edge is E0. RUN occupies edges E1..E_WIDTH. out_valid and the correct product are visible immediately after E_WIDTH, so latency from acceptance to out_valid is WIDTH cycles.
- Back-to-back throughput: with out_ready held high, one result is produced every WIDTH+2 cycles: accept, WIDTH run edges, 1 DONE cycle, then return to IDLE.
- The output handshake edge returns the block to IDLE. in_ready rises after that edge, so a new accept happens no earlier than the following edge.
- Back-pressure: while out_ready=0 in DONE, out_valid stays 1 and product stays stable for any number of cycles.
- Reset mid-operation, in RUN or DONE: after the reset edge the block is in IDLE with reset values. The partial result is discarded and out_valid is never raised for the aborted operation.
- rst and in_valid both high at the same edge: reset wins and the operation is not accepted.

## Test plan
- Reset: hold rst for 2 cycles with in_valid=1 and out_ready=1 -> in_ready=1, out_valid=0, busy=0, product=0; no acceptance occurs.
- Basic, WIDTH=8: a=13, b=11 accepted at E0 -> out_valid rises after E8 with product=143 (0x008F). Pulsing out_ready for one cycle -> out_valid drops and in_ready rises after that edge.
- Corners, WIDTH=8:
  - a=0, b=200 -> 0
  - a=255, b=1 -> 255
  - a=1, b=255 -> 255
  - a=255, b=255 -> 65025 (0xFE01); this checks the carry path.
  - Latency is 8 cycles in every case.
- Back-pressure: product 6*7=42 is ready, out_ready held low for 20 cycles while in_valid=1 with a=3, b=3 -> out_valid stays 1, product stays 42, in_ready stays 0. Releasing out_ready -> the next accept is a=3, b=3, giving 9.
- Reset mid-run: accept a=100, b=100, then assert rst at E4 -> IDLE at E5, out_valid never asserts. A following op a=2, b=3 yields 6 with the normal latency.
- Random: 1000 random (a, b) pairs, with random in_valid gaps and random out_ready stalls -> every product equals a*b, in acceptance order, with no drops and no duplicates.
